// File: rtl/edp_muldiv.sv
// edp_muldiv: iterative signed/unsigned multiply and double-word divide for the EBOX datapath.
// Radix-2 retires one bit per RUN cycle; radix-4 chains two add/subtract stages per cycle.
module edp_muldiv #(
  parameter int WIDTH  = 36,
  parameter bit RADIX4 = 1'b0
) (
  input  logic             CLK,
  input  logic             FPGA_RESET,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic [WIDTH-1:0] opC,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [WIDTH-1:0] resHi,
  output logic [WIDTH-1:0] resLo
);
  localparam int W2 = 2 * WIDTH;
  localparam int N  = RADIX4 ? WIDTH / 2 : WIDTH;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_RUN, S_FIX, S_DONE} state_t;

  state_t           r_state, w_next;
  logic [1:0]       r_op;
  logic [W2-1:0]    r_acc;
  logic [WIDTH-1:0] r_c;
  logic [WIDTH+1:0] r_rem;
  logic [CW-1:0]    r_cnt;
  logic             r_negHi, r_negLo, r_ovf;

  logic             w_signed, w_isDiv, w_sA, w_sB, w_sC, w_divOvf;
  logic [WIDTH-1:0] w_magA, w_magB, w_magC, w_rem, w_remOut, w_quoOut;
  logic [W2-1:0]    w_magDvd, w_mul1, w_mul2, w_mulNext, w_prodOut;
  logic [WIDTH:0]   w_dvdTop;
  logic [W2+1:0]    w_div1, w_div2, w_divNext;

  // Shift-and-add: conditionally add the multiplicand into the high half, then shift right.
  function automatic logic [W2-1:0] mulStep(input logic [W2-1:0] acc, input logic [WIDTH-1:0] m);
    logic [WIDTH:0] sum;
    sum = {1'b0, acc[W2-1:WIDTH]} + (acc[0] ? {1'b0, m} : '0);
    return {sum, acc[WIDTH-1:1]};
  endfunction

  // Non-restoring step: the sign of the partial remainder picks add or subtract.
  function automatic logic [W2+1:0] divStep(input logic [WIDTH+1:0] rem,
                                            input logic [WIDTH-1:0] quo,
                                            input logic [WIDTH-1:0] dvs);
    logic [WIDTH+1:0] sh, nr;
    sh = {rem[WIDTH:0], quo[WIDTH-1]};
    nr = rem[WIDTH+1] ? sh + {2'b00, dvs} : sh - {2'b00, dvs};
    return {nr, quo[WIDTH-2:0], ~nr[WIDTH+1]};
  endfunction

  assign w_signed = ~r_op[0];
  assign w_isDiv  = r_op[1];
  assign w_sA     = w_signed & r_acc[W2-1];
  assign w_sB     = w_signed & r_acc[WIDTH-1];
  assign w_sC     = w_signed & r_c[WIDTH-1];
  assign w_magA   = w_sA ? -r_acc[W2-1:WIDTH] : r_acc[W2-1:WIDTH];
  assign w_magB   = w_sB ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_magC   = w_sC ? -r_c : r_c;
  assign w_magDvd = w_sA ? -r_acc : r_acc;
  // Signed quotients need one spare magnitude bit, so the signed test drops one less bit.
  assign w_dvdTop = w_signed ? w_magDvd[W2-1:WIDTH-1] : {1'b0, w_magDvd[W2-1:WIDTH]};
  assign w_divOvf = (w_magC == '0) | (w_dvdTop >= {1'b0, w_magC});

  assign w_mul1    = mulStep(r_acc, r_c);
  assign w_mul2    = mulStep(w_mul1, r_c);
  assign w_mulNext = RADIX4 ? w_mul2 : w_mul1;
  assign w_div1    = divStep(r_rem, r_acc[WIDTH-1:0], r_c);
  assign w_div2    = divStep(w_div1[W2+1:WIDTH], w_div1[WIDTH-1:0], r_c);
  assign w_divNext = RADIX4 ? w_div2 : w_div1;

  assign w_rem     = r_rem[WIDTH+1] ? r_rem[WIDTH-1:0] + r_c : r_rem[WIDTH-1:0];
  assign w_remOut  = r_negHi ? -w_rem : w_rem;
  assign w_quoOut  = r_negLo ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_prodOut = r_negLo ? -r_acc : r_acc;

  always_ff @(posedge CLK or posedge FPGA_RESET) begin
    if (FPGA_RESET) r_state <= S_IDLE;
    else            r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_CHECK;
      S_CHECK: w_next = (w_isDiv && w_divOvf) ? S_DONE : S_RUN;
      S_RUN:   if (r_cnt == CW'(1)) w_next = S_FIX;
      S_FIX:   w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (r_state != S_IDLE && abort) w_next = S_IDLE;
  end

  always_ff @(posedge CLK or posedge FPGA_RESET) begin
    if (FPGA_RESET) begin
      r_op    <= '0;
      r_acc   <= '0;
      r_c     <= '0;
      r_rem   <= '0;
      r_cnt   <= '0;
      r_negHi <= 1'b0;
      r_negLo <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_op  <= op;
          r_acc <= {opA, opB};
          r_c   <= opC;
          r_ovf <= 1'b0;
        end
        S_CHECK: begin
          r_cnt <= CW'(N);
          if (w_isDiv) begin
            r_ovf <= w_divOvf;
            if (!w_divOvf) begin
              r_acc   <= w_magDvd;
              r_rem   <= {2'b00, w_magDvd[W2-1:WIDTH]};
              r_c     <= w_magC;
              r_negHi <= w_sA;
              r_negLo <= w_sA ^ w_sC;
            end
          end else begin
            r_acc   <= {{WIDTH{1'b0}}, w_magB};
            r_c     <= w_magA;
            r_negHi <= w_sA ^ w_sB;
            r_negLo <= w_sA ^ w_sB;
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt - 1'b1;
          if (w_isDiv) {r_rem, r_acc[WIDTH-1:0]} <= w_divNext;
          else         r_acc <= w_mulNext;
        end
        S_FIX: r_acc <= w_isDiv ? {w_remOut, w_quoOut} : w_prodOut;
        default: ;
      endcase
    end
  end

  assign busy  = (r_state != S_IDLE);
  assign done  = (r_state == S_DONE) & ~abort;
  assign ovf   = r_ovf;
  assign resHi = r_acc[W2-1:WIDTH];
  assign resLo = r_acc[WIDTH-1:0];
endmodule

// File: tb/tb_edp_muldiv.sv
// tb_edp_muldiv: runs a radix-2 and a radix-4 edp_muldiv side by side against a
// plain-arithmetic reference of the multiply/divide results, overflow rule and latency.
module tb_edp_muldiv;
  localparam int W = 36;
  localparam logic signed [79:0] QLIM = 80'sd34359738368;

  logic          CLK = 1'b0;
  logic          FPGA_RESET;
  logic          start, abort;
  logic [1:0]    op;
  logic [W-1:0]  opA, opB, opC;
  logic          busy0, done0, ovf0, busy1, done1, ovf1;
  logic [W-1:0]  hi0, lo0, hi1, lo1;
  int            errors = 0;
  int            checks = 0;

  always #5 CLK = ~CLK;

  edp_muldiv #(.WIDTH(W), .RADIX4(1'b0)) dut0 (
    .CLK(CLK), .FPGA_RESET(FPGA_RESET), .start(start), .abort(abort), .op(op),
    .opA(opA), .opB(opB), .opC(opC), .busy(busy0), .done(done0), .ovf(ovf0),
    .resHi(hi0), .resLo(lo0));

  edp_muldiv #(.WIDTH(W), .RADIX4(1'b1)) dut1 (
    .CLK(CLK), .FPGA_RESET(FPGA_RESET), .start(start), .abort(abort), .op(op),
    .opA(opA), .opB(opB), .opC(opC), .busy(busy1), .done(done1), .ovf(ovf1),
    .resHi(hi1), .resLo(lo1));

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [79:0] got, input logic [79:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference result {ovf, hi, lo} from ordinary wide arithmetic.
  function automatic logic [72:0] model(input logic [1:0] o, input logic [W-1:0] a,
                                        input logic [W-1:0] b, input logic [W-1:0] c);
    logic signed [71:0] sa, sb, sp;
    logic signed [79:0] sd, sc, q, r;
    logic [71:0] ud, uq, ur;
    case (o)
      2'b00: begin
        sa = $signed(a);
        sb = $signed(b);
        sp = sa * sb;
        return {1'b0, sp};
      end
      2'b01: begin
        ud = {36'd0, a} * {36'd0, b};
        return {1'b0, ud};
      end
      2'b11: begin
        if (c == '0 || a >= c) return {1'b1, a, b};
        ud = {a, b};
        uq = ud / {36'd0, c};
        ur = ud % {36'd0, c};
        return {1'b0, ur[35:0], uq[35:0]};
      end
      default: begin
        if (c == '0) return {1'b1, a, b};
        sd = $signed({a, b});
        sc = $signed(c);
        q  = sd / sc;
        r  = sd % sc;
        if (q >= QLIM || q <= -QLIM) return {1'b1, a, b};
        return {1'b0, r[35:0], q[35:0]};
      end
    endcase
  endfunction

  function automatic logic [W-1:0] rnd36();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[35:0];
  endfunction

  // Issue one operation to both engines, then check latency, busy span, results and hold.
  task automatic applyStimulus(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                               input logic [W-1:0] b, input logic [W-1:0] c,
                               input int glitchAt, input bit abortWithStart);
    logic [72:0] exp, r0, r1;
    int e0, e1, b0, b1, lat0, lat1;
    exp  = model(o, a, b, c);
    lat0 = exp[72] ? 2 : W + 3;
    lat1 = exp[72] ? 2 : W / 2 + 3;
    e0 = 0; e1 = 0; b0 = 0; b1 = 0;
    r0 = 'x; r1 = 'x;
    @(negedge CLK);
    op = o; opA = a; opB = b; opC = c;
    start = 1'b1;
    abort = abortWithStart;
    @(posedge CLK);
    @(negedge CLK);
    start = 1'b0;
    abort = 1'b0;
    for (int k = 1; k <= 60 && (e0 == 0 || e1 == 0); k++) begin
      if (busy0) b0++;
      if (busy1) b1++;
      if (done0 && e0 == 0) begin e0 = k; r0 = {ovf0, hi0, lo0}; end
      if (done1 && e1 == 0) begin e1 = k; r1 = {ovf1, hi1, lo1}; end
      start = (k == glitchAt);
      if (k == glitchAt) begin
        op = ~o; opA = ~a; opB = ~b; opC = ~c;
      end
      @(negedge CLK);
    end
    checkOutput({tag, ".lat0"}, 80'(e0), 80'(lat0));
    checkOutput({tag, ".lat1"}, 80'(e1), 80'(lat1));
    checkOutput({tag, ".res0"}, 80'(r0), 80'(exp));
    checkOutput({tag, ".res1"}, 80'(r1), 80'(exp));
    checkOutput({tag, ".busy0"}, 80'(b0), 80'(lat0));
    checkOutput({tag, ".busy1"}, 80'(b1), 80'(lat1));
    checkOutput({tag, ".idle"}, 80'({busy0, done0, busy1, done1}), 80'd0);
    checkOutput({tag, ".hold0"}, 80'({ovf0, hi0, lo0}), 80'(exp));
    checkOutput({tag, ".hold1"}, 80'({ovf1, hi1, lo1}), 80'(exp));
  endtask

  initial begin
    logic [1:0] o;
    logic [W-1:0] a, b, c;
    logic [1:0] mode;
    int seen;
    start = 1'b0; abort = 1'b0; op = '0; opA = '0; opB = '0; opC = '0;
    FPGA_RESET = 1'b0;
    #1 FPGA_RESET = 1'b1;
    #2;
    checkOutput("reset0", 80'({busy0, done0, ovf0, hi0, lo0}), 80'd0);
    checkOutput("reset1", 80'({busy1, done1, ovf1, hi1, lo1}), 80'd0);
    @(negedge CLK);
    @(negedge CLK);
    FPGA_RESET = 1'b0;

    applyStimulus("mulS",     2'b00, 36'(-3), 36'd5, 36'd0, 0, 1'b0);
    applyStimulus("divU",     2'b11, 36'd0, 36'd100, 36'd7, 0, 1'b0);
    applyStimulus("divS",     2'b10, '1, 36'(-100), 36'd7, 0, 1'b0);
    applyStimulus("divS0",    2'b10, '1, 36'(-100), 36'd0, 0, 1'b0);
    applyStimulus("mulUmax",  2'b01, '1, '1, 36'd0, 0, 1'b0);
    applyStimulus("divUeq",   2'b11, 36'd1000, 36'd5, 36'd1000, 0, 1'b0);
    applyStimulus("divUlt",   2'b11, 36'd999, '1, 36'd1000, 0, 1'b0);
    applyStimulus("divSmin",  2'b10, '1, 36'h800000000, 36'd1, 0, 1'b0);
    applyStimulus("divSnear", 2'b10, 36'd0, 36'h7FFFFFFFF, '1, 0, 1'b0);
    applyStimulus("mulSmin",  2'b00, 36'h800000000, 36'h800000000, 36'd0, 0, 1'b0);
    applyStimulus("glitch",   2'b00, 36'd123456, 36'(-789), 36'd0, 5, 1'b0);
    applyStimulus("startAbt", 2'b11, 36'd3, 36'd12345, 36'd1000, 0, 1'b1);

    // Abort during the tenth RUN cycle of a divide.
    @(negedge CLK);
    op = 2'b11; opA = 36'd5; opB = 36'd77; opC = 36'd9;
    start = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    start = 1'b0;
    repeat (10) @(negedge CLK);
    abort = 1'b1;
    @(negedge CLK);
    abort = 1'b0;
    checkOutput("abortIdle", 80'({busy0, done0, busy1, done1}), 80'd0);
    seen = 0;
    repeat (45) begin
      if (done0 || done1 || busy0 || busy1) seen++;
      @(negedge CLK);
    end
    checkOutput("abortNoDone", 80'(seen), 80'd0);
    applyStimulus("afterAbt", 2'b10, 36'd5, 36'd77, 36'(-9), 0, 1'b0);

    // Reset asserted mid-RUN clears everything without waiting for a clock.
    @(negedge CLK);
    op = 2'b01; opA = '1; opB = '1;
    start = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    start = 1'b0;
    repeat (8) @(negedge CLK);
    FPGA_RESET = 1'b1;
    #1;
    checkOutput("midReset0", 80'({busy0, done0, ovf0, hi0, lo0}), 80'd0);
    checkOutput("midReset1", 80'({busy1, done1, ovf1, hi1, lo1}), 80'd0);
    @(negedge CLK);
    FPGA_RESET = 1'b0;

    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      a = rnd36();
      b = rnd36();
      c = rnd36();
      mode = 2'($urandom_range(0, 3));
      if (mode[0]) c = 36'($urandom_range(0, 9));
      if (mode[1]) begin
        if (o[0]) begin
          if (c != '0) a = a % c;
        end else begin
          a = {W{b[W-1]}};
        end
      end
      applyStimulus($sformatf("rnd%0d", i), o, a, b, c, 0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
